// File: rtl/div_arbiter_if.sv
// Requester and divider signal bundle for the shared divider arbiter.
// The slave modport is the arbiter's view; master is the environment side.
interface div_arbiter_if #(
    parameter int NREQ           = 3,
    parameter int WIDTH_DIVIDEND = 26,
    parameter int WIDTH_RES      = 16
);
    logic [NREQ-1:0]                req;
    logic [NREQ*WIDTH_DIVIDEND-1:0] req_dividend;
    logic [NREQ*WIDTH_DIVIDEND-1:0] req_divisor;
    logic [NREQ-1:0]                gnt;
    logic [NREQ-1:0]                done;
    logic [WIDTH_RES-1:0]           result;
    logic                           err;
    logic                           div_start;
    logic [WIDTH_DIVIDEND-1:0]      div_dividend;
    logic [WIDTH_DIVIDEND-1:0]      div_divisor;
    logic                           div_busy;
    logic                           div_ready;
    logic [WIDTH_RES-1:0]           div_result;

    modport slave (
        input  req, req_dividend, req_divisor, div_busy, div_ready, div_result,
        output gnt, done, result, err, div_start, div_dividend, div_divisor
    );

    modport master (
        output req, req_dividend, req_divisor, div_busy, div_ready, div_result,
        input  gnt, done, result, err, div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential divider between several requesters,
// with divide-by-zero short-circuit and a stalled-divider timeout.
module div_arbiter #(
    parameter int NREQ           = 3,
    parameter int WIDTH_DIVIDEND = 26,
    parameter int WIDTH_RES      = 16,
    parameter int TIMEOUT        = 1023
) (
    input  logic         clk,
    input  logic         rst,
    div_arbiter_if.slave bus
);
    localparam int PTR_W  = $clog2(NREQ);
    localparam int TCNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_READY, DELIVER} state_t;

    state_t                    state_q, state_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [PTR_W-1:0]          owner_q, owner_d;
    logic [TCNT_W-1:0]         tcnt_q, tcnt_d;
    logic [NREQ-1:0]           gnt_q, gnt_d;
    logic [NREQ-1:0]           done_q, done_d;
    logic [WIDTH_RES-1:0]      result_q, result_d;
    logic                      err_q, err_d;
    logic                      start_q, start_d;
    logic [WIDTH_DIVIDEND-1:0] dividend_q, dividend_d;
    logic [WIDTH_DIVIDEND-1:0] divisor_q, divisor_d;

    logic [WIDTH_DIVIDEND-1:0] op_dividend [NREQ];
    logic [WIDTH_DIVIDEND-1:0] op_divisor  [NREQ];
    logic                      win_found;
    logic [PTR_W-1:0]          win_idx;
    logic [PTR_W-1:0]          cand;
    logic                      timed_out;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            op_dividend[i] = bus.req_dividend[i*WIDTH_DIVIDEND +: WIDTH_DIVIDEND];
            op_divisor[i]  = bus.req_divisor[i*WIDTH_DIVIDEND +: WIDTH_DIVIDEND];
        end
    end

    // Scan starts just after the last served requester, so service rotates.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % NREQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign timed_out = (tcnt_q >= TCNT_W'(TIMEOUT));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        tcnt_d     = tcnt_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        result_d   = result_q;
        err_d      = err_q;
        start_d    = 1'b0;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_d    = win_idx;
                    gnt_d      = NREQ'(1) << win_idx;
                    dividend_d = op_dividend[win_idx];
                    divisor_d  = op_divisor[win_idx];
                    tcnt_d     = '0;
                    if (op_divisor[win_idx] == '0) begin
                        result_d = '1;
                        err_d    = 1'b1;
                        done_d   = gnt_d;
                        state_d  = DELIVER;
                    end else begin
                        // Strobe is registered, so it is decided one cycle ahead.
                        start_d = !bus.div_busy;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                tcnt_d = tcnt_q + 1'b1;
                if (timed_out) begin
                    result_d = '1;
                    err_d    = 1'b1;
                    done_d   = gnt_q;
                    state_d  = DELIVER;
                end else if (start_q) begin
                    state_d = WAIT_BUSY;
                end else begin
                    start_d = !bus.div_busy;
                end
            end
            WAIT_BUSY: begin
                tcnt_d = tcnt_q + 1'b1;
                if (timed_out) begin
                    result_d = '1;
                    err_d    = 1'b1;
                    done_d   = gnt_q;
                    state_d  = DELIVER;
                end else if (bus.div_busy) begin
                    state_d = WAIT_READY;
                end
            end
            WAIT_READY: begin
                tcnt_d = tcnt_q + 1'b1;
                if (bus.div_ready) begin
                    result_d = bus.div_result;
                    err_d    = 1'b0;
                    done_d   = gnt_q;
                    state_d  = DELIVER;
                end else if (timed_out) begin
                    result_d = '1;
                    err_d    = 1'b1;
                    done_d   = gnt_q;
                    state_d  = DELIVER;
                end
            end
            DELIVER: begin
                ptr_d   = owner_q;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_W'(NREQ - 1);
            owner_q    <= '0;
            tcnt_q     <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            tcnt_q     <= tcnt_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            result_q   <= result_d;
            err_q      <= err_d;
            start_q    <= start_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.done         = done_q;
    assign bus.result       = result_q;
    assign bus.err          = err_q;
    assign bus.div_start    = start_q;
    assign bus.div_dividend = dividend_q;
    assign bus.div_divisor  = divisor_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: a default-timeout instance plus a short-timeout
// instance sharing one behavioural divider model.
module tb_div_arbiter;
    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [77:0] req_dividend;
    logic [77:0] req_divisor;
    logic        sel;
    logic        stall;
    logic        force_busy;
    int          latency;

    logic        m_busy;
    logic        m_ready;
    logic [15:0] m_result;
    int          m_cnt;

    int checks;
    int errors;

    int          n_done;
    int          n_start;
    int          first_start;
    int          done_cyc [8];
    logic [2:0]  done_vec [8];
    logic [15:0] done_res [8];
    logic        done_err [8];

    div_arbiter_if #(.NREQ(3), .WIDTH_DIVIDEND(26), .WIDTH_RES(16)) bus_a ();
    div_arbiter_if #(.NREQ(3), .WIDTH_DIVIDEND(26), .WIDTH_RES(16)) bus_b ();

    div_arbiter #(.NREQ(3), .WIDTH_DIVIDEND(26), .WIDTH_RES(16), .TIMEOUT(1023)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    div_arbiter #(.NREQ(3), .WIDTH_DIVIDEND(26), .WIDTH_RES(16), .TIMEOUT(15)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    assign bus_a.req          = req;
    assign bus_b.req          = req;
    assign bus_a.req_dividend = req_dividend;
    assign bus_b.req_dividend = req_dividend;
    assign bus_a.req_divisor  = req_divisor;
    assign bus_b.req_divisor  = req_divisor;
    assign bus_a.div_busy     = m_busy | force_busy;
    assign bus_b.div_busy     = m_busy | force_busy;
    assign bus_a.div_ready    = m_ready;
    assign bus_b.div_ready    = m_ready;
    assign bus_a.div_result   = m_result;
    assign bus_b.div_result   = m_result;

    logic        obs_start;
    logic [2:0]  obs_done;
    logic [2:0]  obs_gnt;
    logic [15:0] obs_result;
    logic        obs_err;
    logic [25:0] obs_dividend;
    logic [25:0] obs_divisor;

    assign obs_start    = sel ? bus_b.div_start    : bus_a.div_start;
    assign obs_done     = sel ? bus_b.done         : bus_a.done;
    assign obs_gnt      = sel ? bus_b.gnt          : bus_a.gnt;
    assign obs_result   = sel ? bus_b.result       : bus_a.result;
    assign obs_err      = sel ? bus_b.err          : bus_a.err;
    assign obs_dividend = sel ? bus_b.div_dividend : bus_a.div_dividend;
    assign obs_divisor  = sel ? bus_b.div_divisor  : bus_a.div_divisor;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: Busy the cycle after start, Ready `latency` cycles after Busy.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_ready  <= 1'b0;
            m_cnt    <= 0;
            m_result <= '0;
        end else if (m_ready) begin
            m_ready <= 1'b0;
            m_busy  <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_ready  <= 1'b1;
                m_result <= 16'(obs_dividend / obs_divisor);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (obs_start && !stall) begin
            m_busy <= 1'b1;
            m_cnt  <= latency;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic setOperands(input int idx, input int dividend, input int divisor);
        req_dividend[idx*26 +: 26] = 26'(dividend);
        req_divisor[idx*26 +: 26]  = 26'(divisor);
    endtask

    task automatic applyStimulus(input logic [2:0] mask);
        @(posedge clk);
        #1;
        req = mask;
    endtask

    task automatic applyReset();
        req = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Cycle numbers are relative to the IDLE cycle in which the request is seen.
    task automatic watchBus(input int budget, input int want_dones, input bit drop_on_done);
        n_done      = 0;
        n_start     = 0;
        first_start = -1;
        for (int cyc = 1; cyc <= budget && n_done < want_dones; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (obs_start) begin
                n_start++;
                if (first_start < 0) first_start = cyc;
            end
            if (obs_done != '0) begin
                done_cyc[n_done] = cyc;
                done_vec[n_done] = obs_done;
                done_res[n_done] = obs_result;
                done_err[n_done] = obs_err;
                n_done++;
                if (drop_on_done) req = req & ~obs_done;
            end
        end
        checkOutput("doneCount", n_done, want_dones);
    endtask

    initial begin
        int cnt;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        req          = '0;
        req_dividend = '0;
        req_divisor  = '0;
        sel          = 1'b0;
        stall        = 1'b0;
        force_busy   = 1'b0;
        latency      = 17;
        for (int i = 0; i < 8; i++) begin
            done_cyc[i] = 0;
            done_vec[i] = '0;
            done_res[i] = '0;
            done_err[i] = 1'b0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstGnt", bus_a.gnt, 0);
        checkOutput("rstDone", bus_a.done, 0);
        checkOutput("rstResult", bus_a.result, 0);
        checkOutput("rstErr", bus_a.err, 0);
        checkOutput("rstStart", bus_a.div_start, 0);
        checkOutput("rstDividend", bus_a.div_dividend, 0);
        checkOutput("rstDivisor", bus_a.div_divisor, 0);
        rst = 1'b0;

        $display("[TB] single request");
        setOperands(0, 7372, 100);
        applyStimulus(3'b001);
        watchBus(40, 1, 1'b1);
        checkOutput("singleStartCount", n_start, 1);
        checkOutput("singleStartCycle", first_start, 1);
        checkOutput("singleDoneCycle", done_cyc[0], 20);
        checkOutput("singleDoneVec", done_vec[0], 3'b001);
        checkOutput("singleResult", done_res[0], 73);
        checkOutput("singleErr", done_err[0], 0);
        checkOutput("singleGntAtDone", obs_gnt, 3'b001);
        @(posedge clk);
        @(negedge clk);
        checkOutput("singleGntClear", obs_gnt, 0);
        checkOutput("singleResultHeld", obs_result, 73);

        $display("[TB] contention");
        applyReset();
        latency = 3;
        setOperands(0, 60, 6);
        setOperands(1, 84, 4);
        setOperands(2, 1000, 8);
        applyStimulus(3'b111);
        watchBus(60, 3, 1'b1);
        checkOutput("rrVec0", done_vec[0], 3'b001);
        checkOutput("rrVec1", done_vec[1], 3'b010);
        checkOutput("rrVec2", done_vec[2], 3'b100);
        checkOutput("rrCyc0", done_cyc[0], 6);
        checkOutput("rrCyc1", done_cyc[1], 13);
        checkOutput("rrCyc2", done_cyc[2], 20);
        checkOutput("rrRes0", done_res[0], 10);
        checkOutput("rrRes1", done_res[1], 21);
        checkOutput("rrRes2", done_res[2], 125);

        applyReset();
        applyStimulus(3'b110);
        watchBus(80, 4, 1'b0);
        req = '0;
        checkOutput("rr2Vec0", done_vec[0], 3'b010);
        checkOutput("rr2Vec1", done_vec[1], 3'b100);
        checkOutput("rr2Vec2", done_vec[2], 3'b010);
        checkOutput("rr2Vec3", done_vec[3], 3'b100);

        $display("[TB] divide by zero");
        setOperands(1, 1234, 0);
        applyStimulus(3'b010);
        watchBus(10, 1, 1'b1);
        checkOutput("dbzDoneCycle", done_cyc[0], 1);
        checkOutput("dbzDoneVec", done_vec[0], 3'b010);
        checkOutput("dbzResult", done_res[0], 16'hFFFF);
        checkOutput("dbzErr", done_err[0], 1);
        checkOutput("dbzNoStart", n_start, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("dbzDoneClear", obs_done, 0);
        checkOutput("dbzResultHeld", obs_result, 16'hFFFF);

        $display("[TB] divider already busy");
        latency = 5;
        setOperands(0, 50, 5);
        force_busy = 1'b1;
        applyStimulus(3'b001);
        cnt = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (obs_start) cnt++;
        end
        checkOutput("busyNoStart", cnt, 0);
        force_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("busyReleaseStart", obs_start, 1);
        watchBus(40, 1, 1'b1);
        checkOutput("busyDoneVec", done_vec[0], 3'b001);
        checkOutput("busyResult", done_res[0], 10);
        checkOutput("busyErr", done_err[0], 0);

        $display("[TB] stalled divider");
        applyReset();
        sel   = 1'b1;
        stall = 1'b1;
        setOperands(0, 500, 5);
        applyStimulus(3'b001);
        watchBus(40, 1, 1'b1);
        checkOutput("stallStartCycle", first_start, 1);
        checkOutput("stallDoneCycle", done_cyc[0], 17);
        checkOutput("stallDoneVec", done_vec[0], 3'b001);
        checkOutput("stallResult", done_res[0], 16'hFFFF);
        checkOutput("stallErr", done_err[0], 1);
        stall   = 1'b0;
        latency = 4;
        setOperands(1, 90, 9);
        applyStimulus(3'b010);
        watchBus(40, 1, 1'b1);
        checkOutput("afterStallDoneCycle", done_cyc[0], 7);
        checkOutput("afterStallDoneVec", done_vec[0], 3'b010);
        checkOutput("afterStallResult", done_res[0], 10);
        checkOutput("afterStallErr", done_err[0], 0);

        $display("[TB] reset mid-operation");
        applyReset();
        sel     = 1'b0;
        latency = 20;
        setOperands(0, 1000, 10);
        applyStimulus(3'b001);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("preRstGnt", bus_a.gnt, 3'b001);
        #2;
        rst = 1'b1;
        setOperands(2, 77, 7);
        req = 3'b100;
        #1;
        checkOutput("asyncRstGnt", bus_a.gnt, 0);
        checkOutput("asyncRstDone", bus_a.done, 0);
        checkOutput("asyncRstStart", bus_a.div_start, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        watchBus(40, 1, 1'b1);
        checkOutput("postRstDoneVec", done_vec[0], 3'b100);
        checkOutput("postRstDoneCycle", done_cyc[0], 23);
        checkOutput("postRstResult", done_res[0], 11);

        setOperands(0, 1000, 10);
        applyStimulus(3'b001);
        @(posedge clk);
        @(negedge clk);
        checkOutput("strobeBeforeRst", bus_a.div_start, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("strobeAsyncDrop", bus_a.div_start, 0);
        checkOutput("strobeAsyncGnt", bus_a.gnt, 0);
        req = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
